// File: rtl/tx_ring_fifo_if.sv
// Handshake bundle for tx_ring_fifo: transaction control, push and pop sides, status flags.
// The optional level output is present only when TX_RING_FIFO_LEVEL_EN is defined.
interface tx_ring_fifo_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

   logic              ctl_open;
   logic              ctl_commit;
   logic              ctl_rollback;
   logic              push_req;
   logic [DATA_W-1:0] push_data;
   logic              push_done;
   logic              push_err;
   logic              pop_req;
   logic [DATA_W-1:0] pop_data;
   logic              pop_done;
   logic              pop_err;
   logic              empty;
   logic              full;
   logic              tx_active;
`ifdef TX_RING_FIFO_LEVEL_EN
   logic [PTR_W-1:0]  level;

   modport master (
      output ctl_open, ctl_commit, ctl_rollback, push_req, push_data, pop_req,
      input  push_done, push_err, pop_data, pop_done, pop_err, empty, full, tx_active, level
   );
   modport slave (
      input  ctl_open, ctl_commit, ctl_rollback, push_req, push_data, pop_req,
      output push_done, push_err, pop_data, pop_done, pop_err, empty, full, tx_active, level
   );
`else
   modport master (
      output ctl_open, ctl_commit, ctl_rollback, push_req, push_data, pop_req,
      input  push_done, push_err, pop_data, pop_done, pop_err, empty, full, tx_active
   );
   modport slave (
      input  ctl_open, ctl_commit, ctl_rollback, push_req, push_data, pop_req,
      output push_done, push_err, pop_data, pop_done, pop_err, empty, full, tx_active
   );
`endif
endinterface

// File: rtl/tx_ring_fifo.sv
// Transactional register-based ring buffer: writer opens/commits/rolls back, reader sees committed words.
// Define TX_RING_FIFO_LEVEL_EN to add the registered committed-word level output.
module tx_ring_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic          clk,
   input  logic          rst,
   tx_ring_fifo_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
   localparam int unsigned IDX_W = PTR_W - 1;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

   typedef enum logic {IDLE, OPEN} tx_state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   tx_state_t         state_q, state_n;
   logic [PTR_W-1:0]  rd_q, wr_q, cm_q;
   logic [PTR_W-1:0]  rd_n, wr_n, cm_n;
   logic              rb_act, cm_act;
   logic              empty_c, full_c;
   logic              push_ok, push_rej, pop_ok, pop_rej;

   assign empty_c = (rd_q == cm_q);
   assign full_c  = ((wr_q - rd_q) == DEPTH_P);

   always_comb begin
      state_n = state_q;
      rb_act  = 1'b0;
      cm_act  = 1'b0;
      case (state_q)
         IDLE: if (bus.ctl_open) state_n = OPEN;
         OPEN: begin
            if (bus.ctl_rollback) begin
               rb_act  = 1'b1;
               state_n = IDLE;
            end else if (bus.ctl_commit) begin
               cm_act  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A push coinciding with rollback belongs to the discarded frame: no write, no pulse.
   always_comb begin
      push_ok  = bus.push_req && !rb_act && !full_c;
      push_rej = bus.push_req && !rb_act &&  full_c;
      pop_ok   = bus.pop_req  && !empty_c;
      pop_rej  = bus.pop_req  &&  empty_c;
      rd_n     = pop_ok ? (rd_q + ONE_P) : rd_q;
      wr_n     = push_ok ? (wr_q + ONE_P) : wr_q;
      cm_n     = cm_q;
      if (rb_act) begin
         wr_n = cm_q;
      end else if (cm_act || (state_q == IDLE && push_ok)) begin
         cm_n = wr_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         rd_q          <= '0;
         wr_q          <= '0;
         cm_q          <= '0;
         bus.tx_active <= 1'b0;
         bus.push_done <= 1'b0;
         bus.push_err  <= 1'b0;
         bus.pop_done  <= 1'b0;
         bus.pop_err   <= 1'b0;
         bus.pop_data  <= '0;
         bus.empty     <= 1'b1;
         bus.full      <= 1'b0;
      end else begin
         state_q       <= state_n;
         rd_q          <= rd_n;
         wr_q          <= wr_n;
         cm_q          <= cm_n;
         bus.tx_active <= (state_n == OPEN);
         bus.push_done <= push_ok;
         bus.push_err  <= push_rej;
         bus.pop_done  <= pop_ok;
         bus.pop_err   <= pop_rej;
         if (pop_ok) bus.pop_data <= mem[rd_q[IDX_W-1:0]];
         bus.empty     <= (rd_n == cm_n);
         bus.full      <= ((wr_n - rd_n) == DEPTH_P);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q[IDX_W-1:0]] <= bus.push_data;
   end

`ifdef TX_RING_FIFO_LEVEL_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bus.level <= '0;
      else      bus.level <= cm_n - rd_n;
   end
`endif

endmodule

// File: tb/tb_tx_ring_fifo.sv
// Directed bench for tx_ring_fifo at DEPTH=4, DATA_W=16 with immediate-assertion checks.
module tb_tx_ring_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tx_ring_fifo_if #(.DATA_W(16), .DEPTH(4)) bus ();

   tx_ring_fifo #(.DATA_W(16), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulse push_req for one edge; done/err checked in the following cycle.
   task automatic push(input logic [15:0] d, input logic exp_ok);
      bus.push_req  = 1'b1;
      bus.push_data = d;
      @(posedge clk); #1;
      bus.push_req  = 1'b0;
      chk("push_done", {31'b0, bus.push_done}, {31'b0, exp_ok});
      chk("push_err",  {31'b0, bus.push_err},  {31'b0, !exp_ok});
   endtask

   task automatic pop(input logic [15:0] exp_d, input logic exp_ok);
      bus.pop_req = 1'b1;
      @(posedge clk); #1;
      bus.pop_req = 1'b0;
      chk("pop_done", {31'b0, bus.pop_done}, {31'b0, exp_ok});
      chk("pop_err",  {31'b0, bus.pop_err},  {31'b0, !exp_ok});
      chk("pop_data", {16'b0, bus.pop_data}, {16'b0, exp_d});
   endtask

   task automatic ctl(input logic o, input logic c, input logic r);
      bus.ctl_open     = o;
      bus.ctl_commit   = c;
      bus.ctl_rollback = r;
      @(posedge clk); #1;
      bus.ctl_open     = 1'b0;
      bus.ctl_commit   = 1'b0;
      bus.ctl_rollback = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.ctl_open = 1'b0; bus.ctl_commit = 1'b0; bus.ctl_rollback = 1'b0;
      bus.push_req = 1'b0; bus.push_data = '0; bus.pop_req = 1'b0;

      #2 rst = 1'b0;
      #10;
      chk("rst_empty",     {31'b0, bus.empty},     32'd1);
      chk("rst_full",      {31'b0, bus.full},      32'd0);
      chk("rst_tx_active", {31'b0, bus.tx_active}, 32'd0);
      chk("rst_pop_data",  {16'b0, bus.pop_data},  32'd0);
      chk("rst_push_done", {31'b0, bus.push_done}, 32'd0);
      chk("rst_pop_done",  {31'b0, bus.pop_done},  32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // 1: auto-commit pushes, ordered pops
      push(16'hABCD, 1'b1);
      chk("t1_empty", {31'b0, bus.empty}, 32'd0);
      push(16'h1234, 1'b1);
      push(16'h5678, 1'b1);
      @(posedge clk); #1;
      chk("t1_done_pulse", {31'b0, bus.push_done}, 32'd0);
      pop(16'hABCD, 1'b1);
      pop(16'h1234, 1'b1);
      pop(16'h5678, 1'b1);
      chk("t1_empty_end", {31'b0, bus.empty}, 32'd1);

      // 2: fill, overflow rejected, drain, underflow keeps data
      push(16'h0001, 1'b1);
      push(16'h0002, 1'b1);
      push(16'h0003, 1'b1);
      chk("t2_not_full", {31'b0, bus.full}, 32'd0);
      push(16'h0004, 1'b1);
      chk("t2_full", {31'b0, bus.full}, 32'd1);
      push(16'h9999, 1'b0);
      chk("t2_full_hold", {31'b0, bus.full}, 32'd1);
      pop(16'h0001, 1'b1);
      chk("t2_full_clr", {31'b0, bus.full}, 32'd0);
      pop(16'h0002, 1'b1);
      pop(16'h0003, 1'b1);
      pop(16'h0004, 1'b1);
      pop(16'h0004, 1'b0);

      // 3: uncommitted words invisible until commit
      ctl(1'b1, 1'b0, 1'b0);
      chk("t3_tx_active", {31'b0, bus.tx_active}, 32'd1);
      push(16'h1111, 1'b1);
      push(16'h2222, 1'b1);
      pop(16'h0004, 1'b0);
      chk("t3_empty_open", {31'b0, bus.empty}, 32'd1);
      ctl(1'b0, 1'b1, 1'b0);
      chk("t3_tx_idle", {31'b0, bus.tx_active}, 32'd0);
      chk("t3_empty_cm", {31'b0, bus.empty}, 32'd0);
      pop(16'h1111, 1'b1);
      pop(16'h2222, 1'b1);
      chk("t3_empty_end", {31'b0, bus.empty}, 32'd1);

      // 4: rollback discards, space reused
      ctl(1'b1, 1'b0, 1'b0);
      push(16'hAAAA, 1'b1);
      ctl(1'b0, 1'b0, 1'b1);
      chk("t4_tx_idle", {31'b0, bus.tx_active}, 32'd0);
      chk("t4_empty_rb", {31'b0, bus.empty}, 32'd1);
      push(16'hBBBB, 1'b1);
      pop(16'hBBBB, 1'b1);
      pop(16'hBBBB, 1'b0);

      // 5: wrap-around
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) push(16'(3*r + k), 1'b1);
         for (int k = 0; k < 3; k++) pop(16'(3*r + k), 1'b1);
      end
      chk("t5_empty", {31'b0, bus.empty}, 32'd1);

      // commit with same-cycle push includes that word
      ctl(1'b1, 1'b0, 1'b0);
      push(16'h5555, 1'b1);
      bus.ctl_commit = 1'b1;
      push(16'h6666, 1'b1);
      bus.ctl_commit = 1'b0;
      chk("cm_push_empty", {31'b0, bus.empty}, 32'd0);
      pop(16'h5555, 1'b1);
      pop(16'h6666, 1'b1);

      // rollback with same-cycle push: dropped silently
      ctl(1'b1, 1'b0, 1'b0);
      push(16'h7777, 1'b1);
      bus.ctl_rollback = 1'b1;
      bus.push_req = 1'b1; bus.push_data = 16'h8888;
      @(posedge clk); #1;
      bus.ctl_rollback = 1'b0; bus.push_req = 1'b0;
      chk("rb_push_done", {31'b0, bus.push_done}, 32'd0);
      chk("rb_push_err",  {31'b0, bus.push_err},  32'd0);
      chk("rb_empty",     {31'b0, bus.empty},     32'd1);
      pop(16'h6666, 1'b0);

      // simultaneous push and pop
      push(16'hC001, 1'b1);
      bus.pop_req = 1'b1;
      push(16'hC002, 1'b1);
      bus.pop_req = 1'b0;
      chk("pp_pop_done", {31'b0, bus.pop_done}, 32'd1);
      chk("pp_pop_data", {16'b0, bus.pop_data}, 32'h0000C001);
      pop(16'hC002, 1'b1);

      // 6: async reset mid-transaction
      ctl(1'b1, 1'b0, 1'b0);
      push(16'h3333, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("t6_tx_active", {31'b0, bus.tx_active}, 32'd0);
      chk("t6_empty",     {31'b0, bus.empty},     32'd1);
      chk("t6_pop_data",  {16'b0, bus.pop_data},  32'd0);
      chk("t6_full",      {31'b0, bus.full},      32'd0);
      @(negedge clk) rst = 1'b1;
      pop(16'h0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
